// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the staggered reset sequencer: sequencer states,
// channel-count limits and the request priority helper.
package rst_seq_gen_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Lowest set bit wins; returns 0 when nothing is set, so callers gate with |v.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [IDX_W-1:0] k;
        k = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) k = IDX_W'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-to-one synchroniser for the asynchronous external reset request, so a
// request is assumed active until the chain has flushed after reset.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clock) begin
        if (reset) sync_ff <= '1;
        else       sync_ff <= {sync_ff[STAGES-2:0], async_i};
    end

    assign sync_o = sync_ff[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered reset sequencer: holds all requested domain resets, then releases
// them in ascending order with a fixed gap; soft requests restart a suffix.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ext_rst_req_i,
    input  logic [NUM_CH-1:0] sw_rst_req_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic              ready_o
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 ||
        SYNC_STAGES < 2 || CNT_W < 1 ||
        (CNT_W < 31 && (HOLD_CYCLES >= (1 << CNT_W) || STAGGER_CYCLES >= (1 << CNT_W))))
    begin : g_param_err
        $error("rst_seq_gen: parameter out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

    function automatic logic [NUM_CH-1:0] high_mask(input logic [IDX_W-1:0] k);
        logic [NUM_CH-1:0] m;
        for (int i = 0; i < NUM_CH; i++) m[i] = (i >= int'(k));
        return m;
    endfunction

    logic              req_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;      // start channel in HOLD, next channel to clear in RELEASE
    logic [MAX_CH-1:0] sw_pad;
    logic [IDX_W-1:0]  sw_k;
    logic [CNT_W-1:0]  cnt_last;
    logic              restart;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (ext_rst_req_i),
        .sync_o  (req_s)
    );

    assign sw_pad   = MAX_CH'(sw_rst_req_i);
    assign sw_k     = lowest_set(sw_pad);
    assign cnt_last = (state == ST_HOLD) ? HOLD_LAST : STAG_LAST;
    // idx is the lowest still-asserted channel outside RUN, so a soft request
    // only matters if it reaches below what is already being held.
    assign restart  = (|sw_rst_req_i) && (state == ST_RUN || sw_k < idx);

    always_ff @(posedge clock) begin
        if (reset || req_s) begin
            state   <= ST_HOLD;
            rst_o   <= '1;
            cnt     <= '0;
            idx     <= '0;
            ready_o <= 1'b0;
        end else if (restart) begin
            state   <= ST_HOLD;
            rst_o   <= rst_o | high_mask(sw_k);
            cnt     <= '0;
            idx     <= sw_k;
            ready_o <= 1'b0;
        end else if (state != ST_RUN) begin
            if (cnt == cnt_last) begin
                rst_o <= rst_o & ~(NUM_CH'(1) << idx);
                cnt   <= '0;
                if (idx == LAST_CH) begin
                    state   <= ST_RUN;
                    ready_o <= 1'b1;
                end else begin
                    state <= ST_RELEASE;
                    idx   <= idx + IDX_W'(1);
                end
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed release-timing table, hand sequences for
// soft/external restarts, then random traffic against a deadline-based model.
module tb_rst_seq_gen;

    localparam int NUM_CH = 3;
    localparam int HOLD   = 16;
    localparam int STAG   = 4;
    localparam int SYNC   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ext_rst_req_i = 1'b0;
    logic [NUM_CH-1:0] sw_rst_req_i = '0;
    logic [NUM_CH-1:0] rst_o;
    logic              ready_o;

    rst_seq_gen #(
        .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG),
        .SYNC_STAGES(SYNC), .CNT_W(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ext_rst_req_i (ext_rst_req_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .rst_o         (rst_o),
        .ready_o       (ready_o)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: each channel j >= start is held until edge
    // base + HOLD + STAG*(j-start); any restart just moves base/start.
    int                cyc = 0;
    int                m_start = 0;
    int                m_base = 0;
    logic [SYNC-1:0]   m_sync = '1;
    logic [NUM_CH-1:0] exp_rst = '1;
    logic              exp_ready = 1'b0;

    task automatic model_step();
        int   low;
        int   k;
        logic reqs;
        low = NUM_CH;
        for (int j = NUM_CH - 1; j >= 0; j--) if (exp_rst[j]) low = j;
        if (reset) begin
            m_sync  = '1;
            m_start = 0;
            m_base  = cyc;
        end else begin
            reqs   = m_sync[SYNC-1];
            m_sync = {m_sync[SYNC-2:0], ext_rst_req_i};
            if (reqs) begin
                m_start = 0;
                m_base  = cyc;
            end else if (sw_rst_req_i != 0) begin
                k = NUM_CH;
                for (int j = NUM_CH - 1; j >= 0; j--) if (sw_rst_req_i[j]) k = j;
                if (k < low) begin
                    m_start = k;
                    m_base  = cyc;
                end
            end
        end
        for (int j = 0; j < NUM_CH; j++)
            exp_rst[j] = (j >= m_start) && (cyc < m_base + HOLD + STAG * (j - m_start));
        exp_ready = (exp_rst == 0);
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_step();
        #1;
        chk("model_rst", 32'(rst_o), 32'(exp_rst));
        chk("model_ready", 32'(ready_o), 32'(exp_ready));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_out(input string nm, input logic [NUM_CH-1:0] r, input logic rdy);
        chk({nm, "_rst"}, 32'(rst_o), 32'(r));
        chk({nm, "_ready"}, 32'(ready_o), 32'(rdy));
    endtask

    task automatic sw_pulse(input logic [NUM_CH-1:0] v);
        sw_rst_req_i = v;
        tick();
        sw_rst_req_i = '0;
    endtask

    typedef struct {
        int                rel;
        logic [NUM_CH-1:0] rst;
        logic              rdy;
    } vec_t;

    vec_t tbl [9];

    // Edges counted from the last edge at which the request (reset or ext) was still seen.
    task automatic run_table(input int upto);
        for (int r = 1; r <= upto; r++) begin
            tick();
            foreach (tbl[i]) begin
                if (tbl[i].rel == r) expect_out($sformatf("seq@%0d", r), tbl[i].rst, tbl[i].rdy);
            end
        end
    endtask

    initial begin
        int ext_left;
        int rst_left;

        tbl[0] = '{1,  3'b111, 1'b0};
        tbl[1] = '{2,  3'b111, 1'b0};
        tbl[2] = '{17, 3'b111, 1'b0};
        tbl[3] = '{18, 3'b110, 1'b0};
        tbl[4] = '{21, 3'b110, 1'b0};
        tbl[5] = '{22, 3'b100, 1'b0};
        tbl[6] = '{25, 3'b100, 1'b0};
        tbl[7] = '{26, 3'b000, 1'b1};
        tbl[8] = '{30, 3'b000, 1'b1};

        // Power-up
        ticks(3);
        expect_out("reset_state", 3'b111, 1'b0);
        reset = 1'b0;
        run_table(30);

        // Soft request for channel 1 leaves channel 0 running
        sw_pulse(3'b010);
        expect_out("sw1_assert", 3'b110, 1'b0);
        ticks(15);
        expect_out("sw1_hold", 3'b110, 1'b0);
        tick();
        expect_out("sw1_rel1", 3'b100, 1'b0);
        ticks(4);
        expect_out("sw1_run", 3'b000, 1'b1);

        // Channel 2 restart escalated to channel 0 during its hold
        sw_pulse(3'b100);
        expect_out("sw2_assert", 3'b100, 1'b0);
        ticks(5);
        sw_pulse(3'b001);
        expect_out("sw0_escalate", 3'b111, 1'b0);
        ticks(15);
        expect_out("sw0_hold", 3'b111, 1'b0);
        tick();
        expect_out("sw0_rel0", 3'b110, 1'b0);
        ticks(4);
        expect_out("sw0_rel1", 3'b100, 1'b0);
        ticks(4);
        expect_out("sw0_run", 3'b000, 1'b1);

        // External pulse of 5 cycles while running
        ext_rst_req_i = 1'b1;
        ticks(2);
        expect_out("ext_sync_lag", 3'b000, 1'b1);
        tick();
        expect_out("ext_assert", 3'b111, 1'b0);
        ticks(2);
        ext_rst_req_i = 1'b0;
        run_table(30);

        // External request while channel 1 pending, with a soft request alongside
        sw_pulse(3'b001);
        ticks(16);
        expect_out("rel_pending", 3'b110, 1'b0);
        ext_rst_req_i = 1'b1;
        ticks(2);
        expect_out("ext_mid_lag", 3'b110, 1'b0);
        sw_pulse(3'b010);
        expect_out("ext_mid_assert", 3'b111, 1'b0);
        ticks(2);
        ext_rst_req_i = 1'b0;
        run_table(30);

        // Master reset for one cycle mid-release
        sw_pulse(3'b001);
        ticks(20);
        expect_out("pre_reset", 3'b100, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("mid_reset", 3'b111, 1'b0);
        reset = 1'b0;
        run_table(30);

        // Random traffic against the model
        ext_left = 0;
        rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
            end
            if (ext_left > 0) begin
                ext_rst_req_i = 1'b1;
                ext_left--;
            end else begin
                ext_rst_req_i = 1'b0;
                if ($urandom_range(0, 89) == 0) ext_left = $urandom_range(1, 8);
            end
            sw_rst_req_i = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
